pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic control bundle and a generic data bundle between two MIPS pipeline stages.
- Adds a valid/ready handshake and a DEPTH-entry elastic buffer, so a stalled downstream stage no longer forces a global stall.
- Keeps the existing enable (debug step) and flush semantics.

Parameters:
- CTRL_SIZE, 8, width of the control bundle (mem_rd_src, mem_wr_src, wb, halt, ...).
- DATA_SIZE, 64, width of the data bundle (alu_result, bus_b, addr_wr, ...).
- DEPTH, 2, number of buffer entries; legal values 1, 2, 4, 8.
- CNT_SIZE, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  global step enable; when low, all state is frozen.
- i_flush  in  1  synchronous flush; discards all entries.
- i_valid  in  1  upstream presents a bundle.
- o_ready  out  1  buffer can accept a bundle.
- i_ctrl  in  CTRL_SIZE  upstream control bundle.
- i_data  in  DATA_SIZE  upstream data bundle.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts the head entry.
- o_ctrl  out  CTRL_SIZE  head control bundle; all zeros when empty.
- o_data  out  DATA_SIZE  head data bundle; all zeros when empty.
- o_count  out  CNT_SIZE  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, immediate): count=0, read/write pointers=0, o_valid=0, o_ready=1, o_ctrl=0, o_data=0, o_count=0. Storage contents are don't-care.
- Reset mid-operation discards all entries; the first push after deassertion lands in entry 0.
- Handshake definitions:
  - push = i_valid & o_ready & i_enable & ~i_flush
  - pop = o_valid & i_ready & i_enable & ~i_flush
- o_ready = (count < DEPTH):
  - a function of registered state only; no combinational path from i_ready.
  - when full, no push that cycle even if a pop occurs.
- o_valid = (count != 0), from registered state only.
- Outputs o_ctrl and o_data:
  - equal the entry at the read pointer when o_valid = 1;
  - forced to zero when empty, so an empty buffer presents a bubble (NOP, no write-back, halt=0) identical to a cleared stage register.
- Latency: a bundle pushed at edge N appears on o_ctrl/o_data with o_valid=1 after edge N (1 cycle). No same-cycle bypass.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH; DEPTH is a power of two, so wrap is natural overflow of the log2(DEPTH)-bit pointer. For DEPTH=1, pointers are constant 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together (possible only when 0 < count < DEPTH): count unchanged, both pointers advance.
- Flush (sync, priority over push/pop and over i_enable=0):
  - count=0 and read pointer := write pointer after the edge; o_valid=0.
  - a simultaneous i_valid is dropped.
- i_enable=0 without flush:
  - no push or pop; pointers, count and storage hold.
  - o_valid/o_ready/outputs keep showing the held state.
- Empty: pop impossible, since o_valid=0.
- Full: push impossible, since o_ready=0.
- Never overflows or underflows; the design must also carry assertions for both.

Test Plan:
- Reset then single push: DEPTH=2, push ctrl=8'h15, data=64'hA5 at edge 1 with i_ready=0 -> after edge 1 o_valid=1, o_ctrl=8'h15, o_data=64'hA5, o_count=1, o_ready=1.
- Fill and backpressure: push 0x1, 0x2, 0x3 on consecutive cycles with i_ready=0 -> 0x1 and 0x2 accepted, o_count=2, o_ready=0, 0x3 held upstream. Raise i_ready -> outputs 0x1, 0x2, 0x3 in order, no loss or duplication.
- Streaming: i_valid=i_ready=1 for 16 cycles with data=cycle index -> o_count stays 1, o_data lags i_data by exactly 1 cycle, throughput 1 per cycle.
- Flush with push: count=2, assert i_flush and i_valid together -> after edge o_valid=0, o_count=0, o_ctrl=0, o_data=0. Next push reappears 1 cycle later.
- Enable freeze: count=1, i_enable=0 for 5 cycles with i_valid=i_ready=1 -> o_count=1 and outputs unchanged throughout. First enabled edge performs both push and pop.
- Async reset mid-stream: assert i_reset between edges with count=2 -> o_valid=0, o_ready=1, o_count=0 immediately, without waiting for a clock edge. Wrap check: with DEPTH=4, 20 push/pop pairs keep data ordered.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// Elastic inter-stage pipeline buffer (DEPTH-entry FIFO) with debug-step enable and flush; 1-cycle latency, no bypass.
// Backpressure: o_ready is "not full" from registered state only, so i_ready never reaches o_ready combinationally.
module pipe_stage_buffer #(
    parameter int CTRL_SIZE = 8,
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 2,
    parameter int CNT_SIZE  = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [CTRL_SIZE-1:0] i_ctrl,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CTRL_SIZE-1:0] o_ctrl,
    output logic [DATA_SIZE-1:0] o_data,
    output logic [CNT_SIZE-1:0]  o_count
);

    localparam int                  PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_SIZE-1:0] FULL_CNT = CNT_SIZE'(DEPTH);

    logic [CTRL_SIZE-1:0] r_ctrl_mem [DEPTH];
    logic [DATA_SIZE-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_SIZE-1:0]  r_count;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic                 w_valid;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;

    assign w_valid = (r_count != '0);
    assign w_ready = (r_count < FULL_CNT);
    assign w_push  = i_valid & w_ready & i_enable & ~i_flush;
    assign w_pop   = w_valid & i_ready & i_enable & ~i_flush;

    // Power-of-two depth: pointer wrap is plain overflow; a single entry keeps both pointers at 0.
    assign w_wr_ptr_nxt = (DEPTH == 1) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (DEPTH == 1) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_ctrl_mem[r_wr_ptr] <= i_ctrl;
            r_data_mem[r_wr_ptr] <= i_data;
        end
    end

    // An empty buffer presents an all-zero bubble, same as a cleared stage register.
    assign o_ctrl  = w_valid ? r_ctrl_mem[r_rd_ptr] : '0;
    assign o_data  = w_valid ? r_data_mem[r_rd_ptr] : '0;
    assign o_valid = w_valid;
    assign o_ready = w_ready;
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_push && !w_pop && (r_count == FULL_CNT)));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_pop && (r_count == '0)));
    a_count_range: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_count <= FULL_CNT));

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: queue scoreboard plus a vector table (DEPTH=2) and a wrap sequence (DEPTH=4).
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fl;
    logic        v;
    logic        rdy_o;
    logic [7:0]  c;
    logic [63:0] d;
    logic        vld_o;
    logic        r;
    logic [7:0]  c_o;
    logic [63:0] d_o;
    logic [1:0]  cnt_o;

    logic        v4;
    logic        rdy4_o;
    logic [7:0]  c4;
    logic [63:0] d4;
    logic        vld4_o;
    logic        r4;
    logic [7:0]  c4_o;
    logic [63:0] d4_o;
    logic [2:0]  cnt4_o;

    int checks   = 0;
    int failures = 0;

    logic [71:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_stage_buffer #(.CTRL_SIZE(8), .DATA_SIZE(64), .DEPTH(2)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
        .i_valid(v), .o_ready(rdy_o), .i_ctrl(c), .i_data(d),
        .o_valid(vld_o), .i_ready(r), .o_ctrl(c_o), .o_data(d_o), .o_count(cnt_o)
    );

    pipe_stage_buffer #(.CTRL_SIZE(8), .DATA_SIZE(64), .DEPTH(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
        .i_valid(v4), .o_ready(rdy4_o), .i_ctrl(c4), .i_data(d4),
        .o_valid(vld4_o), .i_ready(r4), .o_ctrl(c4_o), .o_data(d4_o), .o_count(cnt4_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle on the DEPTH=2 buffer; pre-edge checks against the scoreboard, then model update.
    task automatic step(input logic iv, input logic [7:0] ic, input logic [63:0] id,
                        input logic ir, input logic ien, input logic ifl);
        logic do_push;
        logic do_pop;
        v = iv; c = ic; d = id; r = ir; en = ien; fl = ifl;
        #1;
        chk("count", 64'(cnt_o), 64'(sb_q.size()));
        chk("valid", 64'(vld_o), 64'(sb_q.size() != 0));
        chk("ready", 64'(rdy_o), 64'(sb_q.size() < 2));
        if (sb_q.size() != 0) begin
            chk("head_ctrl", 64'(c_o), 64'(sb_q[0][71:64]));
            chk("head_data", d_o, sb_q[0][63:0]);
        end else begin
            chk("bubble_ctrl", 64'(c_o), 64'h0);
            chk("bubble_data", d_o, 64'h0);
        end
        do_push = iv && (sb_q.size() < 2) && ien && !ifl;
        do_pop  = (sb_q.size() != 0) && ir && ien && !ifl;
        @(posedge clk);
        if (ifl) sb_q.delete();
        else begin
            if (do_pop)  void'(sb_q.pop_front());
            if (do_push) sb_q.push_back({ic, id});
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        iv;
        logic [7:0]  ic;
        logic [63:0] id;
        logic        ir;
        logic        ien;
        logic        ifl;
        int          exp_cnt;
    } vec_t;

    vec_t tv[20];

    initial begin
        // Table: single push, fill/backpressure, enable freeze, flush with push.
        tv[0]  = '{1'b1, 8'h15, 64'hA5,   1'b0, 1'b1, 1'b0, 1};
        tv[1]  = '{1'b0, 8'h00, 64'h0,    1'b1, 1'b1, 1'b0, 0};
        tv[2]  = '{1'b1, 8'h01, 64'h1001, 1'b0, 1'b1, 1'b0, 1};
        tv[3]  = '{1'b1, 8'h02, 64'h1002, 1'b0, 1'b1, 1'b0, 2};
        tv[4]  = '{1'b1, 8'h03, 64'h1003, 1'b0, 1'b1, 1'b0, 2};
        tv[5]  = '{1'b1, 8'h03, 64'h1003, 1'b1, 1'b1, 1'b0, 1};
        tv[6]  = '{1'b1, 8'h03, 64'h1003, 1'b1, 1'b1, 1'b0, 1};
        tv[7]  = '{1'b0, 8'h00, 64'h0,    1'b1, 1'b1, 1'b0, 0};
        tv[8]  = '{1'b1, 8'h40, 64'h2040, 1'b0, 1'b1, 1'b0, 1};
        tv[9]  = '{1'b1, 8'h41, 64'h2041, 1'b1, 1'b0, 1'b0, 1};
        tv[10] = '{1'b1, 8'h41, 64'h2041, 1'b1, 1'b0, 1'b0, 1};
        tv[11] = '{1'b1, 8'h41, 64'h2041, 1'b1, 1'b0, 1'b0, 1};
        tv[12] = '{1'b1, 8'h41, 64'h2041, 1'b1, 1'b0, 1'b0, 1};
        tv[13] = '{1'b1, 8'h41, 64'h2041, 1'b1, 1'b0, 1'b0, 1};
        tv[14] = '{1'b1, 8'h41, 64'h2041, 1'b1, 1'b1, 1'b0, 1};
        tv[15] = '{1'b1, 8'h50, 64'h3050, 1'b0, 1'b1, 1'b0, 2};
        tv[16] = '{1'b1, 8'h51, 64'h3051, 1'b1, 1'b1, 1'b1, 0};
        tv[17] = '{1'b1, 8'h52, 64'h3052, 1'b0, 1'b1, 1'b0, 1};
        tv[18] = '{1'b0, 8'h00, 64'h0,    1'b1, 1'b1, 1'b0, 0};
        tv[19] = '{1'b0, 8'h00, 64'h0,    1'b0, 1'b1, 1'b0, 0};

        rst = 1'b1; en = 1'b1; fl = 1'b0; v = 1'b0; c = '0; d = '0; r = 1'b0;
        v4 = 1'b0; c4 = '0; d4 = '0; r4 = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(vld_o), 64'h0);
        chk("rst_ready", 64'(rdy_o), 64'h1);
        chk("rst_count", 64'(cnt_o), 64'h0);
        chk("rst_data",  d_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            step(tv[i].iv, tv[i].ic, tv[i].id, tv[i].ir, tv[i].ien, tv[i].ifl);
            chk($sformatf("tbl%0d_count", i), 64'(cnt_o), 64'(tv[i].exp_cnt));
        end
        chk("tbl_first_ctrl_after_push", 64'(tv[0].ic), 64'h15);

        // Streaming: head data must equal the index pushed on the previous edge.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 64'(i), 1'b1, 1'b1, 1'b0);
            chk("stream_count", 64'(cnt_o), 64'h1);
            chk("stream_lag",   d_o, 64'(i));
        end
        step(1'b0, 8'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        chk("stream_drained", 64'(cnt_o), 64'h0);

        // Async reset between edges with two entries held.
        step(1'b1, 8'h61, 64'h6061, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h62, 64'h6062, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_count", 64'(cnt_o), 64'h2);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(vld_o), 64'h0);
        chk("arst_ready", 64'(rdy_o), 64'h1);
        chk("arst_count", 64'(cnt_o), 64'h0);
        chk("arst_ctrl",  64'(c_o), 64'h0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h70, 64'h7070, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        v = 1'b0; r = 1'b0;

        // DEPTH=4 wrap: three entries primed, then 20 push/pop pairs in strict order.
        for (int i = 0; i < 3; i++) begin
            v4 = 1'b1; c4 = 8'(i); d4 = 64'(i) + 64'hC000; r4 = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        chk("w4_fill_count", 64'(cnt4_o), 64'h3);
        for (int i = 0; i < 20; i++) begin
            v4 = 1'b1; c4 = 8'(i + 3); d4 = 64'(i + 3) + 64'hC000; r4 = 1'b1;
            #1;
            chk("w4_valid", 64'(vld4_o), 64'h1);
            chk("w4_ctrl",  64'(c4_o), 64'(8'(i)));
            chk("w4_data",  d4_o, 64'(i) + 64'hC000);
            @(posedge clk); @(negedge clk);
            chk("w4_count", 64'(cnt4_o), 64'h3);
        end
        v4 = 1'b0;
        for (int i = 20; i < 23; i++) begin
            #1;
            chk("w4_drain_data", d4_o, 64'(i) + 64'hC000);
            @(posedge clk); @(negedge clk);
        end
        chk("w4_empty_count", 64'(cnt4_o), 64'h0);
        chk("w4_empty_data",  d4_o, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
